// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage (package fetch_pkg).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
// FETCH_MISALIGN_EN adds the instr_misalign flag to the decode side.
interface instr_fetch_unit_if #(
  parameter int N  = 32,
  parameter int IW = 32
);
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [N-1:0]  instr_pc;
  logic          instr_ready;
`ifdef FETCH_MISALIGN_EN
  logic          instr_misalign;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
`ifdef FETCH_MISALIGN_EN
    output instr_misalign,
`endif
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
`ifdef FETCH_MISALIGN_EN
    input  instr_misalign,
`endif
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, one-entry output buffer, redirect flush.
// Optional FETCH_MISALIGN_EN turns misaligned PCs into a flagged NOP that stalls fetch.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int N  = 32,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic [N-1:0]  pc,
  output logic          pc_load,
  input  logic          redirect,
  instr_fetch_unit_if.master bus
);

  fetch_state_e  state_reg, state_next;
  logic [N-1:0]  pend_pc_reg, pend_pc_next;
  logic [IW-1:0] instr_reg, instr_next;
  logic [N-1:0]  instr_pc_reg, instr_pc_next;
  logic          instr_valid_reg, instr_valid_next;
  logic          req;
  logic          misaligned;
  logic          stalled;
`ifdef FETCH_MISALIGN_EN
  logic          misalign_reg, misalign_next;
`endif

  always_comb begin
    state_next       = state_reg;
    pend_pc_next     = pend_pc_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
    req              = 1'b0;
    misaligned       = 1'b0;
    stalled          = 1'b0;
`ifdef FETCH_MISALIGN_EN
    misalign_next    = misalign_reg;
    misaligned       = |pc[1:0];
    stalled          = misalign_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (!redirect) begin
          if (misaligned) begin
            instr_next       = IW'(NOP_INSTR);
            instr_pc_next    = pc;
            instr_valid_next = 1'b1;
`ifdef FETCH_MISALIGN_EN
            misalign_next    = 1'b1;
`endif
            state_next       = FULL;
          end else begin
            req = 1'b1;
            if (bus.imem_gnt) begin
              pend_pc_next = pc;
              state_next   = WAIT;
            end
          end
        end
      end

      WAIT: begin
        if (bus.imem_rvalid) begin
          // A redirect in the response cycle means the data belongs to the old path.
          if (!redirect) begin
            instr_next       = bus.imem_rdata;
            instr_pc_next    = pend_pc_reg;
            instr_valid_next = 1'b1;
`ifdef FETCH_MISALIGN_EN
            misalign_next    = 1'b0;
`endif
            state_next       = FULL;
          end else begin
            state_next = IDLE;
          end
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end

      FULL: begin
        // Issue the next fetch in the same cycle decode takes the buffer.
        req = bus.instr_ready & !redirect & !stalled;
        if (redirect) begin
          instr_valid_next = 1'b0;
`ifdef FETCH_MISALIGN_EN
          misalign_next    = 1'b0;
`endif
          state_next       = IDLE;
        end else if (bus.instr_ready) begin
          instr_valid_next = 1'b0;
          if (!stalled) begin
            if (bus.imem_gnt) begin
              pend_pc_next = pc;
              state_next   = WAIT;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end

      DRAIN: begin
        if (bus.imem_rvalid) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg       <= IDLE;
      pend_pc_reg     <= N'(RESET_PC);
      instr_reg       <= '0;
      instr_pc_reg    <= N'(RESET_PC);
      instr_valid_reg <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign_reg    <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      pend_pc_reg     <= pend_pc_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
`ifdef FETCH_MISALIGN_EN
      misalign_reg    <= misalign_next;
`endif
    end
  end

  // Request is held off while reset is asserted even though IDLE would otherwise request.
  assign bus.imem_req    = req & n_reset;
  assign bus.imem_addr   = pc;
  assign pc_load         = (bus.imem_req & bus.imem_gnt) | redirect;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
`ifdef FETCH_MISALIGN_EN
  assign bus.instr_misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, reset/misalign
// sequences, then randomized traffic against a transaction-level reference model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        n_reset;
  logic [31:0] pc;
  logic        pc_load;
  logic        redirect;
  logic [31:0] tgt;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if #(.N(32), .IW(32)) bus ();

  instr_fetch_unit #(.N(32), .IW(32)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .pc       (pc),
    .pc_load  (pc_load),
    .redirect (redirect),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: steps by 4 on a load, or takes the redirect target.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) pc <= RESET_PC;
    else if (pc_load) pc <= redirect ? tgt : pc + 32'd4;
  end

  typedef struct {
    logic        rd;
    logic [31:0] t;
    logic        g;
    logic        rv;
    logic [31:0] rdat;
    logic        rdy;
    logic        e_req;
    logic        e_ld;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_i;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  function automatic vec_t mk(logic rd, logic [31:0] t, logic g, logic rv, logic [31:0] rdat,
                              logic rdy, logic e_req, logic e_ld, logic [31:0] e_addr,
                              logic e_v, logic [31:0] e_i, logic [31:0] e_pc);
    vec_t v;
    v.rd = rd; v.t = t; v.g = g; v.rv = rv; v.rdat = rdat; v.rdy = rdy;
    v.e_req = e_req; v.e_ld = e_ld; v.e_addr = e_addr;
    v.e_v = e_v; v.e_i = e_i; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] t, input logic g, input logic rv,
                       input logic [31:0] rdat, input logic rdy);
    redirect        = rd;
    tgt             = t;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdat;
    bus.instr_ready = rdy;
  endtask

  vec_t vecs [32];
  ent_t q[$];
  bit          m_out;
  bit          m_kill;
  logic [31:0] m_pend;
  int          wait_cnt;
  logic        exp_req;

  initial begin
    // Directed program: throughput, grant stall, ready stall, redirects, drain.
    vecs[0]  = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h00,  0, 0, 0);
    vecs[1]  = mk(0, 0,      0, 1, 32'h1111_0001,1,  0, 0, 32'h04,  1, 32'h1111_0001, 32'h00);
    vecs[2]  = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h04,  0, 0, 0);
    vecs[3]  = mk(0, 0,      0, 1, 32'h2222_0002,1,  0, 0, 32'h08,  1, 32'h2222_0002, 32'h04);
    vecs[4]  = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h08,  0, 0, 0);
    vecs[5]  = mk(0, 0,      0, 1, 32'h3333_0003,1,  0, 0, 32'h0C,  1, 32'h3333_0003, 32'h08);
    vecs[6]  = mk(0, 0,      0, 0, 0,            1,  1, 0, 32'h0C,  0, 0, 0);
    vecs[7]  = mk(1, 32'h10, 0, 0, 0,            1,  0, 1, 32'h0C,  0, 0, 0);
    vecs[8]  = mk(0, 0,      0, 0, 0,            1,  1, 0, 32'h10,  0, 0, 0);
    vecs[9]  = mk(0, 0,      0, 0, 0,            1,  1, 0, 32'h10,  0, 0, 0);
    vecs[10] = mk(0, 0,      0, 0, 0,            1,  1, 0, 32'h10,  0, 0, 0);
    vecs[11] = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h10,  0, 0, 0);
    vecs[12] = mk(0, 0,      0, 1, 32'h0050_0093,0,  0, 0, 32'h14,  1, 32'h0050_0093, 32'h10);
    vecs[13] = mk(0, 0,      1, 0, 0,            0,  0, 0, 32'h14,  1, 32'h0050_0093, 32'h10);
    vecs[14] = mk(0, 0,      1, 1, 32'hFFFF_0000,0,  0, 0, 32'h14,  1, 32'h0050_0093, 32'h10);
    vecs[15] = mk(0, 0,      0, 0, 0,            0,  0, 0, 32'h14,  1, 32'h0050_0093, 32'h10);
    vecs[16] = mk(0, 0,      0, 0, 0,            0,  0, 0, 32'h14,  1, 32'h0050_0093, 32'h10);
    vecs[17] = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h14,  0, 0, 0);
    vecs[18] = mk(1, 32'h100,0, 0, 0,            1,  0, 1, 32'h18,  0, 0, 0);
    vecs[19] = mk(0, 0,      0, 0, 0,            1,  0, 0, 32'h100, 0, 0, 0);
    vecs[20] = mk(0, 0,      0, 1, 32'hDEAD_BEEF,1,  0, 0, 32'h100, 0, 0, 0);
    vecs[21] = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h100, 0, 0, 0);
    vecs[22] = mk(1, 32'h40, 0, 1, 32'h0000_0BAD,1,  0, 1, 32'h104, 0, 0, 0);
    vecs[23] = mk(0, 0,      0, 1, 32'h0000_1234,1,  1, 0, 32'h40,  0, 0, 0);
    vecs[24] = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h40,  0, 0, 0);
    vecs[25] = mk(0, 0,      0, 1, 32'h0000_0011,0,  0, 0, 32'h44,  1, 32'h0000_0011, 32'h40);
    vecs[26] = mk(1, 32'h80, 1, 0, 0,            0,  0, 1, 32'h44,  0, 0, 0);
    vecs[27] = mk(0, 0,      1, 0, 0,            1,  1, 1, 32'h80,  0, 0, 0);
    vecs[28] = mk(1, 32'h90, 0, 0, 0,            1,  0, 1, 32'h84,  0, 0, 0);
    vecs[29] = mk(1, 32'hA0, 1, 0, 0,            1,  0, 1, 32'h90,  0, 0, 0);
    vecs[30] = mk(0, 0,      0, 1, 32'h0000_0077,1,  0, 0, 32'hA0,  0, 0, 0);
    vecs[31] = mk(0, 0,      0, 0, 0,            1,  1, 0, 32'hA0,  0, 0, 0);

    n_reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk1("reset req", bus.imem_req, 1'b0);
    chk1("reset pc_load", pc_load, 1'b0);
    chk1("reset valid", bus.instr_valid, 1'b0);
    chk32("reset instr", bus.instr, 32'h0);
    chk32("reset instr_pc", bus.instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_EN
    chk1("reset misalign", bus.instr_misalign, 1'b0);
`endif
    n_reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      drive(vecs[i].rd, vecs[i].t, vecs[i].g, vecs[i].rv, vecs[i].rdat, vecs[i].rdy);
      #1;
      chk1($sformatf("row%0d req", i), bus.imem_req, vecs[i].e_req);
      chk1($sformatf("row%0d pc_load", i), pc_load, vecs[i].e_ld);
      chk32($sformatf("row%0d addr", i), bus.imem_addr, vecs[i].e_addr);
      @(negedge clk);
      chk1($sformatf("row%0d valid", i), bus.instr_valid, vecs[i].e_v);
      if (vecs[i].e_v) begin
        chk32($sformatf("row%0d instr", i), bus.instr, vecs[i].e_i);
        chk32($sformatf("row%0d instr_pc", i), bus.instr_pc, vecs[i].e_pc);
      end
    end

    // Reset while a request is outstanding, then a stale response after release.
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    n_reset = 1'b0;
    #1;
    chk1("rst_wait req", bus.imem_req, 1'b0);
    chk1("rst_wait pc_load", pc_load, 1'b0);
    chk1("rst_wait valid", bus.instr_valid, 1'b0);
    chk32("rst_wait instr", bus.instr, 32'h0);
    chk32("rst_wait instr_pc", bus.instr_pc, 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    drive(0, 0, 0, 1, 32'hCAFE_F00D, 0);
    #1;
    chk1("rst_rel req", bus.imem_req, 1'b1);
    chk32("rst_rel addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk1("late rvalid valid", bus.instr_valid, 1'b0);
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk1("rst_fetch pc_load", pc_load, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h1357_9BDF, 0);
    @(negedge clk);
    chk1("rst_fetch valid", bus.instr_valid, 1'b1);
    chk32("rst_fetch instr", bus.instr, 32'h1357_9BDF);
    chk32("rst_fetch instr_pc", bus.instr_pc, 32'h0);

`ifdef FETCH_MISALIGN_EN
    drive(1, 32'h2, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk1("mis req", bus.imem_req, 1'b0);
    chk1("mis pc_load", pc_load, 1'b0);
    @(negedge clk);
    chk1("mis valid", bus.instr_valid, 1'b1);
    chk32("mis instr", bus.instr, NOP_INSTR);
    chk32("mis instr_pc", bus.instr_pc, 32'h2);
    chk1("mis flag", bus.instr_misalign, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0, 1);
      #1;
      chk1($sformatf("mis stall%0d req", k), bus.imem_req, 1'b0);
      chk1($sformatf("mis stall%0d pc_load", k), pc_load, 1'b0);
      @(negedge clk);
    end
    drive(1, 32'h200, 0, 0, 0, 1);
    #1;
    chk1("mis redirect pc_load", pc_load, 1'b1);
    @(negedge clk);
    chk1("mis cleared", bus.instr_misalign, 1'b0);
    chk1("mis cleared valid", bus.instr_valid, 1'b0);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk1("mis resume req", bus.imem_req, 1'b1);
    chk32("mis resume addr", bus.imem_addr, 32'h200);
    @(negedge clk);
`endif

    // Randomized traffic from a clean reset against the transaction model.
    n_reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_reset  = 1'b1;
    q.delete();
    m_out    = 1'b0;
    m_kill   = 1'b0;
    m_pend   = '0;
    wait_cnt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk1("rnd valid", bus.instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk32("rnd instr", bus.instr, q[0].data);
        chk32("rnd instr_pc", bus.instr_pc, q[0].pc);
        chk32("rnd mem consistency", bus.instr, mem_word(bus.instr_pc));
      end
      redirect        = ($urandom_range(0, 9) == 0);
      tgt             = 32'($urandom_range(0, 1023)) << 2;
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.imem_gnt    = ($urandom_range(0, 9) < 6);
      if (m_out) begin
        bus.imem_rvalid = (wait_cnt >= 4) || ($urandom_range(0, 1) == 0);
        bus.imem_rdata  = mem_word(m_pend);
        wait_cnt++;
      end else begin
        bus.imem_rvalid = ($urandom_range(0, 9) == 0);
        bus.imem_rdata  = $urandom();
        wait_cnt        = 0;
      end
      #1;
      // A new fetch goes out only with nothing in flight and the buffer free or being taken.
      exp_req = !m_out && (q.size() == 0 || bus.instr_ready) && !redirect;
      chk1("rnd req", bus.imem_req, exp_req);
      chk1("rnd pc_load", pc_load, (exp_req && bus.imem_gnt) || redirect);
      chk32("rnd addr", bus.imem_addr, pc);

      if (redirect) q.delete();
      else if (q.size() != 0 && bus.instr_ready) void'(q.pop_front());
      if (m_out && bus.imem_rvalid) begin
        if (!m_kill && !redirect) q.push_back('{pc: m_pend, data: bus.imem_rdata});
        m_out  = 1'b0;
        m_kill = 1'b0;
      end else if (m_out && redirect) begin
        m_kill = 1'b1;
      end
      if (exp_req && bus.imem_gnt) begin
        m_out  = 1'b1;
        m_pend = pc;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
